usb_tx_ctrl: RTL and testbench

Packet sequencer for the USB TX path. Accepts a transmit request, then drives the byte-select code, load strobe and FIFO pop for the 8-bit parallel-to-serial shifter. Each packet is sent as SYNC, then PID, then 0..MAX_PKT_BYTES payload bytes, then EOP. Sits between the protocol/endpoint controller and the TX shift register and encoder.

---
 rtl/usb_tx_pkg.sv | 41 ++++
 rtl/tx_bit_counter.sv | 29 ++
 rtl/usb_tx_ctrl.sv | 168 ++++++++++++++++
 tb/tb_usb_tx_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_tx_pkg.sv
// usb_tx_pkg: shared types and codes for the USB TX packet sequencer.
//   state_t        sequencer states (S_GAP only with USB_TX_IPG_EN)
//   PKT_*          tx_packet request codes
//   SD_*           shifter byte-select codes
//   MAX_PKT_BYTES_DEF  default largest payload
// Optional feature macro: USB_TX_IPG_EN (inter-packet gap state).
package usb_tx_pkg;

  localparam int MAX_PKT_BYTES_DEF = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SYNC,
    S_SYNC,
    S_PID,
    S_DATA,
    S_EOP
`ifdef USB_TX_IPG_EN
    , S_GAP
`endif
  } state_t;

  localparam logic [2:0] PKT_DATA0 = 3'd1;
  localparam logic [2:0] PKT_DATA1 = 3'd2;
  localparam logic [2:0] PKT_ACK   = 3'd3;
  localparam logic [2:0] PKT_NAK   = 3'd4;

  localparam logic [1:0] SD_NONE = 2'd0;
  localparam logic [1:0] SD_SYNC = 2'd1;
  localparam logic [1:0] SD_PID  = 2'd2;
  localparam logic [1:0] SD_DATA = 2'd3;

  function automatic logic pkt_is_data(input logic [2:0] p);
    return (p == PKT_DATA0) || (p == PKT_DATA1);
  endfunction

  function automatic logic pkt_is_legal(input logic [2:0] p);
    return pkt_is_data(p) || (p == PKT_ACK) || (p == PKT_NAK);
  endfunction

endpackage

// File: rtl/tx_bit_counter.sv
// tx_bit_counter: strobe-gated 3-bit counter shared by byte framing,
// the 2-strobe EOP hold and the inter-packet gap.
//   i_clk, i_rst  clock, async active-high reset
//   i_strobe      bit strobe (count enable)
//   i_clr         hold the count at 0 (overrides strobe)
//   i_last        terminal count; o_hit fires on the strobe that sees it
//   o_hit         terminal strobe (byte boundary / end of EOP / end of gap)
module tx_bit_counter (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_strobe,
  input  logic       i_clr,
  input  logic [2:0] i_last,
  output logic       o_hit
);

  logic [2:0] r_cnt;

  assign o_hit = i_strobe && !i_clr && (r_cnt == i_last);

  // The terminal strobe wraps to 0 so the next phase starts counting
  // from a clean boundary without a separate clear.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)          r_cnt <= 3'd0;
    else if (i_clr)     r_cnt <= 3'd0;
    else if (i_strobe)  r_cnt <= o_hit ? 3'd0 : r_cnt + 3'd1;
  end

endmodule

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB TX packet sequencer (SYNC, PID, payload, EOP).
//   i_clk, i_rst             clock, async active-high reset
//   i_tx_start               request pulse (accepted only when idle)
//   i_tx_packet              1=DATA0 2=DATA1 3=ACK 4=NAK
//   i_buffer_occupancy       payload bytes available in the TX FIFO
//   i_bit_strobe             one pulse per USB bit period
//   o_send_data              shifter byte select (0 none,1 SYNC,2 PID,3 data)
//   o_enable_pts             shifter parallel load
//   o_get_tx_packet_data     FIFO pop
//   o_eop                    drive SE0
//   o_tx_transfer_active     busy
//   o_tx_done                completion pulse
//   o_tx_error               illegal-request pulse
// Optional feature macro: USB_TX_IPG_EN adds a GAP state of IPG_BITS strobes.
module usb_tx_ctrl
  import usb_tx_pkg::*;
#(
  parameter int MAX_PKT_BYTES = MAX_PKT_BYTES_DEF
`ifdef USB_TX_IPG_EN
  , parameter int IPG_BITS = 8
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tx_start,
  input  logic [2:0] i_tx_packet,
  input  logic [6:0] i_buffer_occupancy,
  input  logic       i_bit_strobe,
  output logic [1:0] o_send_data,
  output logic       o_enable_pts,
  output logic       o_get_tx_packet_data,
  output logic       o_eop,
  output logic       o_tx_transfer_active,
  output logic       o_tx_done,
  output logic       o_tx_error
);

  localparam logic [7:0] LP_MAX = 8'(MAX_PKT_BYTES);

  state_t     r_state;
  logic [6:0] r_rem;
  logic       r_eop;
  logic       r_active;
  logic       r_done;
  logic       r_err;

  logic       w_hit;
  logic       w_clr;
  logic [2:0] w_last;
  logic       w_bad_req;

  logic [1:0] w_send;
  logic       w_load;
  logic       w_pop;

  assign w_clr = (r_state == S_IDLE) || (r_state == S_WAIT_SYNC);

  always_comb begin
    w_last = 3'd7;
    case (r_state)
      S_EOP:   w_last = 3'd1;
`ifdef USB_TX_IPG_EN
      S_GAP:   w_last = 3'(IPG_BITS - 1);
`endif
      default: w_last = 3'd7;
    endcase
  end

  tx_bit_counter u_cnt (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_strobe (i_bit_strobe),
    .i_clr    (w_clr),
    .i_last   (w_last),
    .o_hit    (w_hit)
  );

  assign w_bad_req = !pkt_is_legal(i_tx_packet) ||
                     (pkt_is_data(i_tx_packet) && ({1'b0, i_buffer_occupancy} > LP_MAX));

  // Load controls must coincide with the strobe that also shifts the
  // shifter, so they are decoded from registered state and the strobe.
  always_comb begin
    w_load = 1'b0;
    w_send = SD_NONE;
    w_pop  = 1'b0;
    case (r_state)
      S_WAIT_SYNC: if (i_bit_strobe) begin
        w_load = 1'b1;
        w_send = SD_SYNC;
      end
      S_SYNC: if (w_hit) begin
        w_load = 1'b1;
        w_send = SD_PID;
      end
      S_PID, S_DATA: if (w_hit && (r_rem != 7'd0)) begin
        w_load = 1'b1;
        w_send = SD_DATA;
        w_pop  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= S_IDLE;
      r_rem    <= 7'd0;
      r_eop    <= 1'b0;
      r_active <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        // r_done blocks a request landing in the completion cycle.
        S_IDLE: if (i_tx_start && !r_done) begin
          if (w_bad_req) begin
            r_err <= 1'b1;
          end else begin
            r_rem    <= pkt_is_data(i_tx_packet) ? i_buffer_occupancy : 7'd0;
            r_active <= 1'b1;
            r_state  <= S_WAIT_SYNC;
          end
        end
        S_WAIT_SYNC: if (i_bit_strobe) r_state <= S_SYNC;
        S_SYNC:      if (w_hit) r_state <= S_PID;
        S_PID, S_DATA: if (w_hit) begin
          if (r_rem != 7'd0) begin
            r_rem   <= r_rem - 7'd1;
            r_state <= S_DATA;
          end else begin
            r_eop   <= 1'b1;
            r_state <= S_EOP;
          end
        end
        S_EOP: if (w_hit) begin
          r_eop <= 1'b0;
`ifdef USB_TX_IPG_EN
          r_state <= S_GAP;
`else
          r_done   <= 1'b1;
          r_active <= 1'b0;
          r_state  <= S_IDLE;
`endif
        end
`ifdef USB_TX_IPG_EN
        S_GAP: if (w_hit) begin
          r_done   <= 1'b1;
          r_active <= 1'b0;
          r_state  <= S_IDLE;
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_send_data          = w_send;
  assign o_enable_pts         = w_load;
  assign o_get_tx_packet_data = w_pop;
  assign o_eop                = r_eop;
  assign o_tx_transfer_active = r_active;
  assign o_tx_done            = r_done;
  assign o_tx_error           = r_err;

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: directed bench for usb_tx_ctrl with a load-event scoreboard.
module tb_usb_tx_ctrl;

`ifdef USB_TX_IPG_EN
  localparam int GAP = 8;
`else
  localparam int GAP = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_start = 1'b0;
  logic [2:0] tx_packet = 3'd0;
  logic [6:0] occupancy = 7'd0;
  logic       bit_strobe = 1'b0;
  logic       strb_en = 1'b0;
  logic [1:0] send_data;
  logic       enable_pts, get_data, eop, active, tx_done, tx_error;

  usb_tx_ctrl dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_tx_start           (tx_start),
    .i_tx_packet          (tx_packet),
    .i_buffer_occupancy   (occupancy),
    .i_bit_strobe         (bit_strobe),
    .o_send_data          (send_data),
    .o_enable_pts         (enable_pts),
    .o_get_tx_packet_data (get_data),
    .o_eop                (eop),
    .o_tx_transfer_active (active),
    .o_tx_done            (tx_done),
    .o_tx_error           (tx_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int code;
    int pop;
    int at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0, failures = 0;
  int  sidx = 0, exp_done = -1, eop_strobes = 0, done_cnt = 0, pops = 0;

  task automatic check(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Strobe every 4th clock.
  initial begin
    int cyc = 0;
    forever begin
      @(posedge clk); #1;
      bit_strobe = strb_en && (cyc % 4 == 3);
      cyc++;
    end
  end

  // Monitor: strobe index counts strobes seen while busy, so the SYNC
  // load lands on strobe 1, each byte is 8 strobes, EOP holds 2.
  always @(negedge clk) begin
    ev_t ev;
    if (!rst) begin
      if (bit_strobe && active) sidx++;
      if (enable_pts || get_data) begin
        if (exp_q.size() == 0) check("unexpected_load", sidx, -1);
        else begin
          ev = exp_q.pop_front();
          check("load_en", int'(enable_pts), 1);
          check("load_code", int'(send_data), ev.code);
          check("load_pop", int'(get_data), ev.pop);
          check("load_at", sidx, ev.at);
          check("load_on_strobe", int'(bit_strobe), 1);
        end
      end else begin
        check("idle_select", int'(send_data), 0);
      end
      if (get_data) pops++;
      if (eop && bit_strobe) eop_strobes++;
      if (tx_done) begin
        done_cnt++;
        check("done_at", sidx, exp_done);
      end
    end
  end

  task automatic expect_pkt(input int rem);
    exp_q.delete();
    exp_q.push_back('{1, 0, 1});
    exp_q.push_back('{2, 0, 9});
    for (int k = 0; k < rem; k++) exp_q.push_back('{3, 1, 17 + 8 * k});
    exp_done    = 19 + 8 * rem + GAP;
    sidx        = 0;
    eop_strobes = 0;
    done_cnt    = 0;
    pops        = 0;
  endtask

  task automatic pulse_start(input logic [2:0] p, input logic [6:0] occ);
    @(posedge clk); #1;
    tx_packet = p; occupancy = occ; tx_start = 1'b1;
    @(posedge clk); #1;
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!tx_done && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (!tx_done) check("done_timeout", 0, 1);
  endtask

  task automatic wait_sidx(input int target);
    int n = 0;
    while (sidx < target && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (sidx < target) check("sidx_timeout", sidx, target);
  endtask

  task automatic post_pkt(input string tag, input int npops);
    @(negedge clk); #1;
    check({tag, "_left"}, exp_q.size(), 0);
    check({tag, "_eop"}, eop_strobes, 2);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_pops"}, pops, npops);
    check({tag, "_idle"}, int'(active), 0);
  endtask

  task automatic run_pkt(input string tag, input logic [2:0] p, input logic [6:0] occ,
                         input int rem);
    expect_pkt(rem);
    pulse_start(p, occ);
    check({tag, "_busy"}, int'(active), 1);
    wait_done(400 + 40 * rem);
    post_pkt(tag, rem);
  endtask

  task automatic bad_req(input string tag, input logic [2:0] p, input logic [6:0] occ);
    exp_q.delete();
    pulse_start(p, occ);
    check({tag, "_err"}, int'(tx_error), 1);
    check({tag, "_act"}, int'(active), 0);
    @(posedge clk); #1;
    check({tag, "_err_clr"}, int'(tx_error), 0);
    repeat (12) @(posedge clk);
    #1 check({tag, "_still_idle"}, int'(active), 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_send"}, int'(send_data), 0);
    check({tag, "_en"}, int'(enable_pts), 0);
    check({tag, "_pop"}, int'(get_data), 0);
    check({tag, "_eop"}, int'(eop), 0);
    check({tag, "_act"}, int'(active), 0);
    check({tag, "_done"}, int'(tx_done), 0);
    check({tag, "_err"}, int'(tx_error), 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(posedge clk); #1 rst = 1'b0;
    strb_en = 1'b1;

    run_pkt("ack", 3'd3, 7'd0, 0);
    run_pkt("data1_3", 3'd2, 7'd3, 3);

    // Zero-length DATA0, with a request landing in the tx_done cycle.
    expect_pkt(0);
    pulse_start(3'd1, 7'd0);
    wait_done(400);
    tx_packet = 3'd3; tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    check("race_ignored", int'(active), 0);
    post_pkt("data0_0", 0);
    repeat (8) @(posedge clk);
    #1 check("race_still_idle", int'(active), 0);

    bad_req("pkt0", 3'd0, 7'd0);
    bad_req("pkt5", 3'd5, 7'd1);
    bad_req("occ65", 3'd1, 7'd65);
    run_pkt("nak_occ100", 3'd4, 7'd100, 0);
    run_pkt("data0_64", 3'd1, 7'd64, 64);

    // Second request while busy must not disturb the packet.
    expect_pkt(2);
    pulse_start(3'd1, 7'd2);
    wait_sidx(5);
    pulse_start(3'd3, 7'd0);
    wait_done(600);
    post_pkt("busy_ign", 2);

    // Reset during the 2nd payload byte.
    expect_pkt(3);
    pulse_start(3'd2, 7'd3);
    wait_sidx(27);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    check("midrst_pops", pops, 2);
    exp_q.delete();
    exp_done = -1;
    @(posedge clk); #1 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("midrst_no_done", done_cnt, 0);

    run_pkt("after_rst", 3'd3, 7'd0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
